serial_word_framer: RTL

- Upstream feeder for the byte-wide serial transmitter.
- Accepts a 32-bit word and sends it as a frame of bytes: optional sync byte, four data bytes LSB first, optional XOR checksum byte.
- Drives the transmitter's byte_in and start inputs and paces them off its ready output, so the transmitter never misses a start edge.
- Sits between the control/telemetry logic and the transmitter, in the same clk (bit-rate) domain.

---
 rtl/serial_word_framer_if.sv | 22 ++
 rtl/serial_word_framer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_word_framer_if.sv
// Request and transmitter-side signals of the serial word framer.
// master = control logic plus transmitter side, slave = the framer itself.
interface serial_word_framer_if;
    logic [31:0] word_in;
    logic        word_valid;
    logic        busy;
    logic [7:0]  byte_out;
    logic        tx_start;
    logic        tx_ready;
    logic        frame_done;
    logic        timeout_err;

    modport master (
        output word_in, word_valid, tx_ready,
        input  busy, byte_out, tx_start, frame_done, timeout_err
    );

    modport slave (
        input  word_in, word_valid, tx_ready,
        output busy, byte_out, tx_start, frame_done, timeout_err
    );
endinterface

// File: rtl/serial_word_framer.sv
// Frames a 32-bit word as [sync] b0 b1 b2 b3 [xor] and paces each byte into the
// byte-wide serial transmitter off its ready output.
//   state     | meaning
//   IDLE      | waiting for word_valid with transmitter ready
//   SETUP     | load byte_out with the current frame byte
//   PULSE     | one-cycle tx_start
//   WAIT_ACK  | waiting for ready to drop (transmitter took the byte)
//   WAIT_DONE | waiting for ready to return
//   GAP       | spacing before the next byte or end of frame
module serial_word_framer #(
    parameter bit         SYNC_EN    = 1'b1,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter bit         CHK_EN     = 1'b1,
    parameter int         GAP_CYCLES = 2,
    parameter int         TIMEOUT    = 32
) (
    input logic                 clk,
    input logic                 reset_n,
    serial_word_framer_if.slave bus
);

    localparam int         N        = 4 + int'(SYNC_EN) + int'(CHK_EN);
    localparam logic [2:0] LAST_IDX = 3'(N - 1);
    localparam logic [5:0] TO_LAST  = 6'(TIMEOUT - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_WAIT_ACK, S_WAIT_DONE, S_GAP
    } state_t;

    state_t      r_state,   w_state_nxt;
    logic [31:0] r_word,    w_word_nxt;
    logic [7:0]  r_chk,     w_chk_nxt;
    logic [2:0]  r_idx,     w_idx_nxt;
    logic [7:0]  r_gap_cnt, w_gap_cnt_nxt;
    logic [5:0]  r_to_cnt,  w_to_cnt_nxt;
    logic        r_busy,    w_busy_nxt;
    logic [7:0]  r_byte,    w_byte_nxt;

    logic [1:0]  w_data_idx;
    logic [7:0]  w_frame_byte;
    logic        w_tx_start;
    logic        w_frame_done;
    logic        w_timeout_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_word    <= '0;
            r_chk     <= '0;
            r_idx     <= '0;
            r_gap_cnt <= '0;
            r_to_cnt  <= '0;
            r_busy    <= 1'b0;
            r_byte    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_word    <= w_word_nxt;
            r_chk     <= w_chk_nxt;
            r_idx     <= w_idx_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_busy    <= w_busy_nxt;
            r_byte    <= w_byte_nxt;
        end
    end

    // Frame position -> data byte position, skipping the sync slot when present.
    always_comb begin
        w_data_idx = 2'(r_idx - 3'(SYNC_EN));
        case (w_data_idx)
            2'd0:    w_frame_byte = r_word[7:0];
            2'd1:    w_frame_byte = r_word[15:8];
            2'd2:    w_frame_byte = r_word[23:16];
            default: w_frame_byte = r_word[31:24];
        endcase
        if (SYNC_EN && (r_idx == 3'd0)) begin
            w_frame_byte = SYNC_BYTE;
        end else if (CHK_EN && (r_idx == LAST_IDX)) begin
            w_frame_byte = r_chk;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_word_nxt    = r_word;
        w_chk_nxt     = r_chk;
        w_idx_nxt     = r_idx;
        w_gap_cnt_nxt = r_gap_cnt;
        w_to_cnt_nxt  = r_to_cnt;
        w_busy_nxt    = r_busy;
        w_byte_nxt    = r_byte;
        w_tx_start    = 1'b0;
        w_frame_done  = 1'b0;
        w_timeout_err = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (bus.word_valid && bus.tx_ready) begin
                    w_word_nxt  = bus.word_in;
                    w_chk_nxt   = bus.word_in[7:0] ^ bus.word_in[15:8] ^
                                  bus.word_in[23:16] ^ bus.word_in[31:24];
                    w_idx_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_byte_nxt  = w_frame_byte;
                w_state_nxt = S_PULSE;
            end
            S_PULSE: begin
                w_tx_start   = 1'b1;
                w_to_cnt_nxt = '0;
                w_state_nxt  = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!bus.tx_ready) begin
                    w_to_cnt_nxt = '0;
                    w_state_nxt  = S_WAIT_DONE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_timeout_err = 1'b1;
                    w_busy_nxt    = 1'b0;
                    w_to_cnt_nxt  = '0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 6'd1;
                end
            end
            S_WAIT_DONE: begin
                if (bus.tx_ready) begin
                    w_gap_cnt_nxt = GAP_LOAD;
                    w_state_nxt   = S_GAP;
                end else if (r_to_cnt == TO_LAST) begin
                    w_timeout_err = 1'b1;
                    w_busy_nxt    = 1'b0;
                    w_to_cnt_nxt  = '0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 6'd1;
                end
            end
            S_GAP: begin
                if (r_gap_cnt <= 8'd1) begin
                    w_gap_cnt_nxt = '0;
                    if (r_idx == LAST_IDX) begin
                        w_frame_done = 1'b1;
                        w_busy_nxt   = 1'b0;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_state_nxt = S_SETUP;
                    end
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 8'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.busy        = r_busy;
    assign bus.byte_out    = r_byte;
    assign bus.tx_start    = w_tx_start;
    assign bus.frame_done  = w_frame_done;
    assign bus.timeout_err = w_timeout_err;

endmodule
